// File: rtl/snn_timestep_scheduler.sv
// rtl/snn_timestep_scheduler.sv - timestep sequencer for one SNN layer (optional spike counters: SNN_SPIKE_COUNT_EN)
module snn_timestep_scheduler #(
    parameter int M = 2,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_spikes,
    input  logic [3:0]     settle_cycles,
    output logic [M-1:0]   layer_input_spikes,
    output logic           layer_delay_clk,
    output logic           layer_enable,
    input  logic [N-1:0]   layer_output_spikes,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_spikes,
    output logic [7:0]     timestep,
    output logic           busy
`ifdef SNN_SPIKE_COUNT_EN
    ,
    input  logic           clear_counts,
    output logic [N*8-1:0] spike_counts
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DLY    = 3'd1;
    localparam logic [2:0] ST_INT    = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [M-1:0] lin_q, lin_d;
    logic [N-1:0] ospk_q, ospk_d;
    logic [7:0]   ts_q, ts_d;
    logic         capture;

    // Layer strobes and handshakes come straight from the state register so they are glitch-free.
    assign in_ready           = (state_q == ST_IDLE);
    assign layer_delay_clk    = (state_q == ST_DLY);
    assign layer_enable       = (state_q == ST_INT);
    assign out_valid          = (state_q == ST_OUT);
    assign busy               = (state_q != ST_IDLE);
    assign layer_input_spikes = lin_q;
    assign out_spikes         = ospk_q;
    assign timestep           = ts_q;

    assign capture = (state_q == ST_SETTLE) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lin_d   = lin_q;
        ospk_d  = ospk_q;
        ts_d    = ts_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    lin_d   = in_spikes;
                    state_d = ST_DLY;
                end
            end
            ST_DLY: begin
                state_d = ST_INT;
            end
            ST_INT: begin
                cnt_d   = settle_cycles;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ospk_d  = layer_output_spikes;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    ts_d    = ts_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            lin_q   <= '0;
            ospk_q  <= '0;
            ts_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lin_q   <= lin_d;
            ospk_q  <= ospk_d;
            ts_q    <= ts_d;
        end
    end

`ifdef SNN_SPIKE_COUNT_EN
    logic [N-1:0][7:0] cnts_q, cnts_d;

    // Per-neuron saturating counters; a clear overrides a same-edge increment.
    always_comb begin
        cnts_d = cnts_q;
        for (int i = 0; i < N; i++) begin
            if (clear_counts) begin
                cnts_d[i] = 8'd0;
            end else if (capture && layer_output_spikes[i] && (cnts_q[i] != 8'hFF)) begin
                cnts_d[i] = cnts_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnts_q <= '0;
        end else begin
            cnts_q <= cnts_d;
        end
    end

    assign spike_counts = cnts_q;
`endif

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb/tb_snn_timestep_scheduler.sv - scoreboard bench for snn_timestep_scheduler
module tb_snn_timestep_scheduler;
    localparam int M = 2;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] spk;
        int           rise;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   in_spikes;
    logic [3:0]     settle_cycles;
    logic [M-1:0]   layer_input_spikes;
    logic           layer_delay_clk;
    logic           layer_enable;
    logic [N-1:0]   layer_output_spikes;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_spikes;
    logic [7:0]     timestep;
    logic           busy;
    logic           clear_counts;
    logic [N*8-1:0] spike_counts;

    int   cyc;
    int   n_chk;
    int   n_pass;
    int   ts_exp;
    bit   force0;
    logic [N-1:0] last_cap;
    exp_t exp_q[$];

    snn_timestep_scheduler #(.M(M), .N(N)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_spikes           (in_spikes),
        .settle_cycles       (settle_cycles),
        .layer_input_spikes  (layer_input_spikes),
        .layer_delay_clk     (layer_delay_clk),
        .layer_enable        (layer_enable),
        .layer_output_spikes (layer_output_spikes),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_spikes          (out_spikes),
        .timestep            (timestep),
        .busy                (busy)
`ifdef SNN_SPIKE_COUNT_EN
        ,
        .clear_counts        (clear_counts),
        .spike_counts        (spike_counts)
`endif
    );

`ifndef SNN_SPIKE_COUNT_EN
    assign spike_counts = '0;
`endif

    // Layer model: output pattern changes every cycle so the capture cycle is observable.
    function automatic logic [N-1:0] lo_pat(input int c);
        logic [31:0] t;
        t = c * 7 + 3;
        return t[N-1:0];
    endfunction

    assign layer_output_spikes = lo_pat(cyc) | N'(force0);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_step(input logic [M-1:0] spk, input logic [3:0] s, input int hold,
                           input bit keep_valid, output int k);
        int   guard;
        exp_t e;
        logic [N-1:0] held;
        in_spikes     = spk;
        settle_cycles = s;
        in_valid      = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        else n_pass++;
        k = cyc;
        exp_q.push_back('{spk: lo_pat(k + 3 + int'(s)) | N'(force0), rise: k + 4 + int'(s)});
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        n_chk++;
        if ({layer_delay_clk, layer_enable, busy, in_ready} !== 4'b1010)
            $display("FAIL dly_cycle dly/en/busy/rdy=%b required 1010", {layer_delay_clk, layer_enable, busy, in_ready});
        else n_pass++;
        n_chk++;
        if (layer_input_spikes !== spk) $display("FAIL layer_in got %b required %b", layer_input_spikes, spk);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({layer_delay_clk, layer_enable} !== 2'b01)
            $display("FAIL int_cycle dly/en=%b required 01", {layer_delay_clk, layer_enable});
        else n_pass++;
        @(negedge clk);
        settle_cycles = ~s;
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        e = exp_q.pop_front();
        n_chk++;
        if (out_valid !== 1'b1 || cyc !== e.rise)
            $display("FAIL out_valid_rise cycle=%0d valid=%b required cycle %0d", cyc, out_valid, e.rise);
        else n_pass++;
        n_chk++;
        if (out_spikes !== e.spk) $display("FAIL out_spikes got %b required %b", out_spikes, e.spk);
        else n_pass++;
        last_cap = e.spk;
        held = out_spikes;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_spikes !== held || layer_input_spikes !== spk)
                $display("FAIL out_hold valid=%b rdy=%b spk=%b lin=%b required 1 0 %b %b",
                         out_valid, in_ready, out_spikes, layer_input_spikes, held, spk);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        ts_exp = (ts_exp + 1) % 256;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_return valid=%b rdy=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        else n_pass++;
        n_chk++;
        if (timestep !== ts_exp[7:0]) $display("FAIL timestep got %0d required %0d", timestep, ts_exp);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({in_ready, busy, out_valid, layer_delay_clk, layer_enable} !== 5'b10000)
            $display("FAIL reset_ctrl rdy/busy/val/dly/en=%b required 10000",
                     {in_ready, busy, out_valid, layer_delay_clk, layer_enable});
        else n_pass++;
        n_chk++;
        if (timestep !== 8'd0 || out_spikes !== '0 || layer_input_spikes !== '0)
            $display("FAIL reset_data ts=%0d out=%b lin=%b required 0", timestep, out_spikes, layer_input_spikes);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int k;
        int t0;
        t0 = cyc;
        do_step(2'b01, 4'd0, 0, 1'b0, k);
        n_chk++;
        if (k !== t0) $display("FAIL first_accept cycle=%0d required %0d", k, t0);
        else n_pass++;
        do_step(2'b10, 4'd1, 2, 1'b0, k);
    endtask

    task automatic test_settle_max;
        int k;
        do_step(2'b11, 4'd15, 0, 1'b0, k);
        do_step(2'b01, 4'd7, 1, 1'b0, k);
    endtask

    task automatic test_back_to_back;
        int k;
        int t0;
        do_step(2'b11, 4'd3, 10, 1'b1, k);
        t0 = cyc;
        do_step(2'b10, 4'd2, 0, 1'b0, k);
        n_chk++;
        if (k !== t0) $display("FAIL b2b_accept cycle=%0d required %0d", k, t0);
        else n_pass++;
    endtask

    task automatic test_wrap;
        int k;
        for (int i = 0; i < 256; i++) begin
            do_step(M'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 0, 1'b0, k);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        in_spikes = 2'b10;
        settle_cycles = 4'd8;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || layer_delay_clk !== 1'b0 || layer_enable !== 1'b0)
            $display("FAIL settle_entry busy=%b required 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({in_ready, busy, out_valid, layer_delay_clk, layer_enable} !== 5'b10000)
            $display("FAIL midreset_ctrl rdy/busy/val/dly/en=%b required 10000",
                     {in_ready, busy, out_valid, layer_delay_clk, layer_enable});
        else n_pass++;
        n_chk++;
        if (timestep !== 8'd0 || out_spikes !== '0 || layer_input_spikes !== '0)
            $display("FAIL midreset_data ts=%0d out=%b lin=%b required 0", timestep, out_spikes, layer_input_spikes);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ts_exp = 0;
        do_step(2'b01, 4'd4, 0, 1'b0, k);
    endtask

`ifdef SNN_SPIKE_COUNT_EN
    task automatic test_spike_counts;
        int k;
        int model[N];
        logic [N*8-1:0] exp_v;
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        for (int i = 0; i < N; i++) model[i] = 0;
        force0 = 1'b1;
        for (int t = 0; t < 300; t++) begin
            do_step(2'b01, 4'd0, 0, 1'b0, k);
            for (int i = 0; i < N; i++)
                if (last_cap[i] && model[i] < 255) model[i]++;
        end
        for (int i = 0; i < N; i++) exp_v[i*8 +: 8] = 8'(model[i]);
        n_chk++;
        if (spike_counts[7:0] !== 8'd255) $display("FAIL count_sat got %0d required 255", spike_counts[7:0]);
        else n_pass++;
        n_chk++;
        if (spike_counts !== exp_v) $display("FAIL count_all got %h required %h", spike_counts, exp_v);
        else n_pass++;
        clear_counts = 1'b1;
        do_step(2'b01, 4'd0, 0, 1'b0, k);
        clear_counts = 1'b0;
        n_chk++;
        if (spike_counts !== '0) $display("FAIL count_clear got %h required 0", spike_counts);
        else n_pass++;
        force0 = 1'b0;
    endtask
`endif

    initial begin
        n_chk = 0;
        n_pass = 0;
        ts_exp = 0;
        force0 = 1'b0;
        last_cap = '0;
        in_valid = 1'b0;
        in_spikes = '0;
        settle_cycles = 4'd0;
        out_ready = 1'b0;
        clear_counts = 1'b0;
        rst_n = 1'b0;
        test_reset;
        test_basic;
        test_settle_max;
        test_back_to_back;
        test_wrap;
        test_reset_mid;
`ifdef SNN_SPIKE_COUNT_EN
        test_spike_counts;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/snn_timestep_scheduler.md
SNN_TIMESTEP_SCHEDULER -- requirements
Module: snn_timestep_scheduler

Interface
REQ-001 SHALL have parameter M, default 2, number of input spike lines.
REQ-002 SHALL have parameter N, default 4, number of neurons in the sequenced layer.
REQ-003 SHALL have port clk, input, 1, the single clock for the block; all flops on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, an input spike frame is offered.
REQ-006 SHALL have port in_ready, output, 1, the scheduler accepts the frame this cycle.
REQ-007 SHALL have port in_spikes, input, M, the input spike frame.
REQ-008 SHALL have port settle_cycles, input, 4, extra wait cycles after integration (S).
REQ-009 SHALL have port layer_input_spikes, output, M, registered spikes driven to the layer.
REQ-010 SHALL have port layer_delay_clk, output, 1, one-cycle delay-line advance pulse.
REQ-011 SHALL have port layer_enable, output, 1, one-cycle layer integrate pulse.
REQ-012 SHALL have port layer_output_spikes, input, N, spike outputs from the layer.
REQ-013 SHALL have port out_valid, output, 1, a captured result frame is available.
REQ-014 SHALL have port out_ready, input, 1, the consumer accepts the result frame.
REQ-015 SHALL have port out_spikes, output, N, captured layer spikes.
REQ-016 SHALL have port timestep, output, 8, count of completed timesteps.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, DLY, INT, SETTLE and OUT; in_ready, layer_delay_clk, layer_enable, busy and out_valid SHALL decode from the state register only.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch in_spikes into layer_input_spikes and go to DLY.
REQ-020 DLY SHALL last exactly 1 cycle with layer_delay_clk=1, then go to INT.
REQ-021 INT SHALL last exactly 1 cycle with layer_enable=1, then go to SETTLE, loading a 4-bit counter from settle_cycles sampled on that edge.
REQ-022 SETTLE SHALL decrement the counter while it is nonzero and SHALL last S+1 cycles; S=0 gives 1 cycle.
REQ-023 On the SETTLE->OUT edge, out_spikes SHALL load layer_output_spikes.
REQ-024 Latency: if the input handshake completes at the end of cycle k, DLY is k+1, INT is k+2, SETTLE is k+3..k+3+S, and out_valid rises in cycle k+4+S.
REQ-025 OUT: out_valid=1; out_valid and out_spikes SHALL hold stable until out_ready=1.
REQ-026 On the out_valid&&out_ready edge: go to IDLE and increment timestep modulo 256 (255->0).
REQ-027 in_ready SHALL be 0 outside IDLE, so in_valid in OUT is not accepted; earliest re-accept is the cycle after the output handshake.
REQ-028 layer_input_spikes SHALL hold its value until the next accepted frame.
REQ-029 changes on settle_cycles outside the INT->SETTLE edge SHALL have no effect on the current timestep.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE from any state, including mid-sequence.
REQ-031 During reset, layer_input_spikes, out_spikes, timestep, the counter, layer_delay_clk, layer_enable, out_valid and busy SHALL be 0, and in_ready SHALL be 1.
REQ-032 The first accept SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-033 With macro SNN_SPIKE_COUNT_EN defined, the block SHALL add input clear_counts (1 bit) and output spike_counts (N*8 bits), with neuron i at bits [i*8 +: 8].
REQ-034 With SNN_SPIKE_COUNT_EN defined, spike_counts[i] SHALL increment on the SETTLE->OUT edge when layer_output_spikes[i]=1, saturate at 255, reset to 0, and clear synchronously on clear_counts; clear wins over a simultaneous increment.
REQ-035 Without SNN_SPIKE_COUNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then in_spikes=2'b01 with in_valid for 1 cycle and S=0: delay_clk is high at k+1 and enable at k+2; out_valid rises at k+4; out_spikes equals the layer value at k+3.
REQ-037 S=15 with out_ready held 1: out_valid rises at k+19; IDLE at k+20; timestep=1.
REQ-038 out_ready held 0 for 10 cycles in OUT with in_valid=1 throughout: out_spikes is stable; no accept occurs; in_ready=0; the accept happens on the cycle after the handshake.
REQ-039 Run 256 timesteps: timestep reads 255 and then 0.
REQ-040 Assert rst_n=0 during SETTLE: all outputs take their reset values immediately; the following frame runs normally.
REQ-041 With SNN_SPIKE_COUNT_EN, 300 steps with neuron 0 always spiking: spike_counts[7:0]=255; clear_counts asserted on the same edge as a spike gives 0.
